// File: rtl/tick_generator_if.sv
// Configuration handshake and per-channel tick outputs shared between
// the tick generator and whatever drives its configuration port.
interface tick_generator_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 25
) ();
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en;
    logic              cfg_valid;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_oneshot;
    logic              cfg_ready;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] slow_clk;
    logic [NUM_CH-1:0] busy;

    modport master (
        output en, cfg_valid, cfg_ch, cfg_div, cfg_oneshot,
        input  cfg_ready, tick, slow_clk, busy
    );

    modport slave (
        input  en, cfg_valid, cfg_ch, cfg_div, cfg_oneshot,
        output cfg_ready, tick, slow_clk, busy
    );
endinterface

// File: rtl/tick_generator.sv
// Multi-channel programmable divider: each channel emits a one-cycle tick every
// div cycles (periodic) or once (one-shot), plus a square wave toggling per tick.
module tick_generator #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 25,
    parameter int DEF_DIV = 13500
) (
    input  logic            clk,
    input  logic            rst,
    tick_generator_if.slave bus
);
    localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [CNT_W-1:0]  div_q    [NUM_CH];
    logic [CNT_W-1:0]  div_d    [NUM_CH];
    logic [CNT_W-1:0]  sh_div_q [NUM_CH];
    logic [CNT_W-1:0]  sh_div_d [NUM_CH];
    logic [NUM_CH-1:0] mode_q,    mode_d;
    logic [NUM_CH-1:0] sh_mode_q, sh_mode_d;
    logic [NUM_CH-1:0] run_q,     run_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] tick_q,    tick_d;
    logic [NUM_CH-1:0] slow_q,    slow_d;
    logic [NUM_CH-1:0] busy_q,    busy_d;
    logic [NUM_CH-1:0] hit_s, idle_s, tc_s;
    logic              cfg_ready_s;

    // A channel with a deferred write refuses further writes; unknown channels always accept.
    always_comb begin
        cfg_ready_s = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.cfg_ch == CH_W'(i)) begin
                cfg_ready_s = ~pending_q[i];
            end else begin
                cfg_ready_s = cfg_ready_s;
            end
        end
    end

    // Per-channel next state: immediate writes first, then counting and shadow hand-over.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]     = cnt_q[i];
            div_d[i]     = div_q[i];
            sh_div_d[i]  = sh_div_q[i];
            mode_d[i]    = mode_q[i];
            sh_mode_d[i] = sh_mode_q[i];
            run_d[i]     = run_q[i];
            pending_d[i] = pending_q[i];
            tick_d[i]    = 1'b0;
            slow_d[i]    = slow_q[i];

            hit_s[i]  = bus.cfg_valid && cfg_ready_s && (bus.cfg_ch == CH_W'(i));
            idle_s[i] = !bus.en[i] || (div_q[i] == ZERO_C) || (mode_q[i] && !run_q[i]);
            tc_s[i]   = bus.en[i] && (div_q[i] != ZERO_C) && (!mode_q[i] || run_q[i])
                        && (cnt_q[i] == (div_q[i] - ONE_C));

            if (hit_s[i] && (idle_s[i] || bus.cfg_oneshot)) begin
                div_d[i]  = bus.cfg_div;
                mode_d[i] = bus.cfg_oneshot;
                run_d[i]  = bus.cfg_oneshot;
                cnt_d[i]  = ZERO_C;
            end else begin
                // pending_q is 0 whenever a write is accepted, so a fresh shadow never applies this edge
                if (hit_s[i]) begin
                    sh_div_d[i]  = bus.cfg_div;
                    sh_mode_d[i] = 1'b0;
                    pending_d[i] = 1'b1;
                end else begin
                    pending_d[i] = pending_q[i];
                end

                if (!bus.en[i]) begin
                    cnt_d[i] = ZERO_C;
                    if (pending_q[i]) begin
                        div_d[i]     = sh_div_q[i];
                        mode_d[i]    = sh_mode_q[i];
                        pending_d[i] = 1'b0;
                    end else begin
                        div_d[i] = div_q[i];
                    end
                end else if ((div_q[i] == ZERO_C) || (mode_q[i] && !run_q[i])) begin
                    cnt_d[i] = ZERO_C;
                end else if (tc_s[i]) begin
                    cnt_d[i]  = ZERO_C;
                    tick_d[i] = 1'b1;
                    slow_d[i] = ~slow_q[i];
                    run_d[i]  = mode_q[i] ? 1'b0 : run_q[i];
                    if (pending_q[i]) begin
                        div_d[i]     = sh_div_q[i];
                        mode_d[i]    = sh_mode_q[i];
                        pending_d[i] = 1'b0;
                    end else begin
                        div_d[i] = div_q[i];
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE_C;
                end
            end

            busy_d[i] = run_d[i] & mode_d[i];
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= ZERO_C;
                div_q[i]    <= DEF_DIV_C;
                sh_div_q[i] <= ZERO_C;
            end
            mode_q    <= '0;
            sh_mode_q <= '0;
            run_q     <= '0;
            pending_q <= '0;
            tick_q    <= '0;
            slow_q    <= '0;
            busy_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            sh_div_q  <= sh_div_d;
            mode_q    <= mode_d;
            sh_mode_q <= sh_mode_d;
            run_q     <= run_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            slow_q    <= slow_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_s;
    assign bus.tick      = tick_q;
    assign bus.slow_clk  = slow_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_tick_generator.sv
// Scenario bench for tick_generator (NUM_CH=2, CNT_W=8, DEF_DIV=4) plus a
// three-channel instance for out-of-range channel writes.
module tb_tick_generator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tick_generator_if #(.NUM_CH(2), .CNT_W(8)) bus  ();
    tick_generator_if #(.NUM_CH(3), .CNT_W(8)) bus3 ();

    tick_generator #(.NUM_CH(2), .CNT_W(8), .DEF_DIV(4)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    tick_generator #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(4)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct packed {
        logic [3:0] tick;
        logic [3:0] slow;
        logic [3:0] busy;
        logic       ready;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic do_reset(input logic [1:0] en_v, input logic [2:0] en3_v);
        rst = 1'b0;
        bus.en = en_v;           bus.cfg_valid = 1'b0;  bus.cfg_ch = 1'b0;
        bus.cfg_div = 8'd0;      bus.cfg_oneshot = 1'b0;
        bus3.en = en3_v;         bus3.cfg_valid = 1'b0; bus3.cfg_ch = 2'd0;
        bus3.cfg_div = 8'd0;     bus3.cfg_oneshot = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e, got;
        rst = 1'b0;
        bus.en = 2'b11; bus.cfg_valid = 1'b0; bus.cfg_ch = 1'b0; bus.cfg_div = 8'd0; bus.cfg_oneshot = 1'b0;
        bus3.en = 3'b000; bus3.cfg_valid = 1'b0; bus3.cfg_ch = 2'd0; bus3.cfg_div = 8'd0; bus3.cfg_oneshot = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e = '0; e.ready = 1'b1;
            sb_q.push_back(e);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = sb_q.pop_front();
            got = '0; got.tick[1:0] = bus.tick; got.slow[1:0] = bus.slow_clk;
            got.busy[1:0] = bus.busy; got.ready = bus.cfg_ready;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset k=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    task automatic test_periodic();
        exp_t e, got;
        do_reset(2'b01, 3'b000);
        for (int k = 1; k <= 16; k++) begin
            e = '0;
            e.tick[0] = (k % 4 == 0);
            e.slow[0] = ((k / 4) % 2 == 1);
            e.ready   = 1'b1;
            sb_q.push_back(e);
        end
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); @(negedge clk);
            e = sb_q.pop_front();
            got = '0; got.tick[1:0] = bus.tick; got.slow[1:0] = bus.slow_clk;
            got.busy[1:0] = bus.busy; got.ready = bus.cfg_ready;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL periodic k=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    task automatic test_shadow_write();
        exp_t e, got;
        int   nt;
        do_reset(2'b01, 3'b000);
        for (int k = 1; k <= 17; k++) begin
            nt = int'(k >= 4) + int'(k >= 10) + int'(k >= 16);
            e = '0;
            e.tick[0] = (k == 4) || (k == 10) || (k == 16);
            e.slow[0] = (nt % 2 == 1);
            e.ready   = !((k == 2) || (k == 3));
            sb_q.push_back(e);
        end
        for (int k = 1; k <= 17; k++) begin
            bus.cfg_valid = (k == 2); bus.cfg_ch = 1'b0; bus.cfg_div = 8'd6; bus.cfg_oneshot = 1'b0;
            @(posedge clk); @(negedge clk);
            e = sb_q.pop_front();
            got = '0; got.tick[1:0] = bus.tick; got.slow[1:0] = bus.slow_clk;
            got.busy[1:0] = bus.busy; got.ready = bus.cfg_ready;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL shadow_write k=%0d got=%h exp=%h", k, got, e);
            end
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_oneshot();
        exp_t e, got;
        do_reset(2'b11, 3'b000);
        for (int k = 1; k <= 14; k++) begin
            e = '0;
            e.tick[0] = (k % 4 == 0);
            e.slow[0] = ((k / 4) % 2 == 1);
            e.tick[1] = (k == 4);
            e.slow[1] = (k >= 4);
            e.busy[1] = (k >= 1) && (k <= 3);
            e.ready   = 1'b1;
            sb_q.push_back(e);
        end
        for (int k = 1; k <= 14; k++) begin
            bus.cfg_valid = (k == 1); bus.cfg_ch = 1'b1; bus.cfg_div = 8'd3; bus.cfg_oneshot = 1'b1;
            @(posedge clk); @(negedge clk);
            e = sb_q.pop_front();
            got = '0; got.tick[1:0] = bus.tick; got.slow[1:0] = bus.slow_clk;
            got.busy[1:0] = bus.busy; got.ready = bus.cfg_ready;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL oneshot k=%0d got=%h exp=%h", k, got, e);
            end
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_div0_div1();
        exp_t e, got;
        do_reset(2'b01, 3'b000);
        for (int k = 1; k <= 16; k++) begin
            e = '0;
            if (k < 4) begin
                e.tick[0] = 1'b0; e.slow[0] = 1'b0;
            end else if (k == 4) begin
                e.tick[0] = 1'b1; e.slow[0] = 1'b1;
            end else if (k <= 10) begin
                e.tick[0] = 1'b0; e.slow[0] = 1'b1;
            end else begin
                e.tick[0] = 1'b1; e.slow[0] = ((k - 10) % 2 == 0);
            end
            e.ready = !((k == 2) || (k == 3));
            sb_q.push_back(e);
        end
        for (int k = 1; k <= 16; k++) begin
            bus.cfg_valid = (k == 2) || (k == 10);
            bus.cfg_ch = 1'b0; bus.cfg_oneshot = 1'b0;
            bus.cfg_div = (k == 10) ? 8'd1 : 8'd0;
            @(posedge clk); @(negedge clk);
            e = sb_q.pop_front();
            got = '0; got.tick[1:0] = bus.tick; got.slow[1:0] = bus.slow_clk;
            got.busy[1:0] = bus.busy; got.ready = bus.cfg_ready;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL div0_div1 k=%0d got=%h exp=%h", k, got, e);
            end
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_tc_edge_and_reset();
        exp_t e, got;
        int   nt;
        do_reset(2'b01, 3'b000);
        // Write lands on the first TC edge, so the 4-cycle period repeats once more.
        for (int k = 1; k <= 17; k++) begin
            nt = int'(k >= 4) + int'(k >= 8) + int'(k >= 14);
            e = '0;
            e.tick[0] = (k == 4) || (k == 8) || (k == 14);
            e.slow[0] = (nt % 2 == 1);
            e.ready   = !(((k >= 4) && (k <= 7)) || (k == 17));
            sb_q.push_back(e);
        end
        for (int k = 1; k <= 17; k++) begin
            bus.cfg_valid = (k == 4) || (k == 17);
            bus.cfg_ch = 1'b0; bus.cfg_oneshot = 1'b0;
            bus.cfg_div = (k == 17) ? 8'd9 : 8'd6;
            @(posedge clk); @(negedge clk);
            e = sb_q.pop_front();
            got = '0; got.tick[1:0] = bus.tick; got.slow[1:0] = bus.slow_clk;
            got.busy[1:0] = bus.busy; got.ready = bus.cfg_ready;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL tc_edge k=%0d got=%h exp=%h", k, got, e);
            end
        end
        bus.cfg_valid = 1'b0;
        e = '0; e.ready = 1'b1;
        sb_q.push_back(e);
        #2 rst = 1'b0;
        #1;
        e = sb_q.pop_front();
        got = '0; got.tick[1:0] = bus.tick; got.slow[1:0] = bus.slow_clk;
        got.busy[1:0] = bus.busy; got.ready = bus.cfg_ready;
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", got, e);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            e = '0;
            e.tick[0] = (k % 4 == 0);
            e.slow[0] = ((k / 4) % 2 == 1);
            e.ready   = 1'b1;
            sb_q.push_back(e);
        end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            e = sb_q.pop_front();
            got = '0; got.tick[1:0] = bus.tick; got.slow[1:0] = bus.slow_clk;
            got.busy[1:0] = bus.busy; got.ready = bus.cfg_ready;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL post_reset k=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    task automatic test_bad_channel();
        exp_t e, got;
        do_reset(2'b00, 3'b111);
        for (int k = 1; k <= 12; k++) begin
            e = '0;
            e.tick[2:0] = (k % 4 == 0) ? 3'b111 : 3'b000;
            e.slow[2:0] = ((k / 4) % 2 == 1) ? 3'b111 : 3'b000;
            e.ready     = 1'b1;
            sb_q.push_back(e);
        end
        for (int k = 1; k <= 12; k++) begin
            bus3.cfg_valid = (k >= 2) && (k <= 5);
            bus3.cfg_ch = 2'd3; bus3.cfg_div = 8'd0; bus3.cfg_oneshot = 1'b1;
            @(posedge clk); @(negedge clk);
            e = sb_q.pop_front();
            got = '0; got.tick[2:0] = bus3.tick; got.slow[2:0] = bus3.slow_clk;
            got.busy[2:0] = bus3.busy; got.ready = bus3.cfg_ready;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL bad_channel k=%0d got=%h exp=%h", k, got, e);
            end
        end
        bus3.cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_shadow_write();
        test_oneshot();
        test_div0_div1();
        test_tc_edge_and_reset();
        test_bad_channel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/tick_generator.md
TICK_GENERATOR -- requirements
Module: tick_generator

Interface
REQ-001 SHALL have parameter NUM_CH, 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, 25, divisor/counter width in bits.
REQ-003 SHALL have parameter DEF_DIV, 13500, per-channel divisor loaded at reset (1 kHz slow_clk from 27 MHz).
REQ-004 SHALL define CH_W = max(1, clog2(NUM_CH)).
REQ-005 SHALL have one clock and asynchronous active-low reset: `clk  in  1  system clock` and `rst  in  1  asynchronous active-low reset`.
REQ-006 SHALL have port `en  in  NUM_CH  per-channel run enable`.
REQ-007 SHALL have port `cfg_valid  in  1  configuration write request`.
REQ-008 SHALL have port `cfg_ch  in  CH_W  target channel`.
REQ-009 SHALL have port `cfg_div  in  CNT_W  new divisor`.
REQ-010 SHALL have port `cfg_oneshot  in  1  1 = one-shot mode, 0 = periodic`.
REQ-011 SHALL have port `cfg_ready  out  1  write can be accepted`.
REQ-012 SHALL have port `tick  out  NUM_CH  registered one-cycle terminal-count pulse`.
REQ-013 SHALL have port `slow_clk  out  NUM_CH  registered square wave, toggles on each tick`.
REQ-014 SHALL have port `busy  out  NUM_CH  one-shot armed and counting`.

Function
REQ-015 Each channel SHALL hold cnt[CNT_W], div, mode, run flag, shadow div/mode and a pending flag.
REQ-016 Terminal count (TC) is defined as: en=1, div!=0, (mode periodic or run=1), and cnt==div-1 at a clock edge.
REQ-017 At TC the channel SHALL set cnt<=0, tick<=1, toggle slow_clk, and clear run if mode is one-shot.
REQ-018 When counting without TC, the channel SHALL set cnt<=cnt+1 and tick<=0, giving a period of exactly div cycles and a slow_clk period of 2*div cycles.
REQ-019 With div==1 in periodic mode, tick SHALL stay high continuously and slow_clk SHALL toggle every cycle.
REQ-020 With en=0 the channel SHALL clear cnt to 0 and drive tick 0, while slow_clk holds its value.
REQ-021 With div==0 the channel SHALL be halted: cnt held 0, tick 0, slow_clk held.
REQ-022 In one-shot mode with run=0, the channel SHALL hold cnt at 0 and drive tick 0.
REQ-023 busy SHALL equal run AND mode-is-one-shot.
REQ-024 A write SHALL be accepted when cfg_valid and cfg_ready are both high at a clock edge.
REQ-025 cfg_ready SHALL be combinational and equal NOT pending[cfg_ch]; it SHALL be 1 when cfg_ch >= NUM_CH.
REQ-026 An accepted write with cfg_ch >= NUM_CH SHALL be ignored.
REQ-027 An accepted write to an idle channel (en=0, div==0, or one-shot with run=0) SHALL load div and mode immediately, clear cnt, and set run=cfg_oneshot.
REQ-028 An accepted write with cfg_oneshot=1 SHALL always apply immediately as in REQ-027, restarting any running count.
REQ-029 An accepted periodic write to a running periodic channel SHALL go to the shadow registers and set pending=1.
REQ-030 The shadow SHALL be applied at that channel's next TC edge, together with clearing pending, so the next period uses the new div.
REQ-031 A periodic write accepted on the same edge as that channel's TC SHALL NOT apply at that TC; it SHALL wait for the following TC.
REQ-032 If en falls while pending=1, the shadow SHALL be applied on the first edge with en=0 and pending SHALL be cleared.
REQ-033 Channels SHALL be fully independent; simultaneous TCs on several channels SHALL all be honoured in the same cycle.

Reset
REQ-034 While rst=0 (asynchronous), every channel SHALL be forced to: cnt=0, div=DEF_DIV, mode=periodic, run=0, pending=0, shadow cleared; and outputs tick=0, slow_clk=0, busy=0.
REQ-035 Counting SHALL begin on the first clock edge after rst deasserts.
REQ-036 Reset mid-operation SHALL discard pending writes and one-shot state.

Verification (NUM_CH=2, CNT_W=8, DEF_DIV=4)
REQ-037 Reset release with en=2'b01 -> tick[0] pulses every 4 cycles, slow_clk[0] period 8 cycles, channel 1 tick=0 and slow_clk[1]=0.
REQ-038 Periodic write of div=6 to running ch0 mid-period -> pending set, cfg_ready=0 for cfg_ch=0, current period stays 4, following periods 6, ready returns after the TC.
REQ-039 One-shot write of div=3 to ch1 with en[1]=1 -> busy[1]=1, exactly one tick[1] 3 cycles later, then busy[1]=0 with no further ticks.
REQ-040 Write of div=0 -> ch halts, slow_clk frozen; a later write of div=1 -> tick held high and slow_clk toggles each cycle.
REQ-041 Write landing on the TC edge, and rst pulsed low mid-count -> write defers one full period; reset forces all outputs 0 immediately and restores DEF_DIV.
REQ-042 cfg_ch=3 write -> cfg_ready=1, no channel state changes.
